// File: rtl/sbox_lane_pipe_if.sv
// ----------------------------------------------------------------------------
// sbox_lane_pipe_if
// Valid/ready bus for the S-box lane pipeline: one upstream channel (data,
// mode, tag) and one downstream channel (data, tag).
//   in_valid/in_ready   upstream handshake
//   in_inv              0 = forward S-box, 1 = inverse S-box
//   in_data/in_tag      LANES bytes (lane k = in_data[8k+7:8k]) and sideband
//   out_valid/out_ready downstream handshake
//   out_data/out_tag    substituted bytes and the tag of that transaction
// modport slave  : the substitution engine
// modport master : the producer/consumer around it
// ----------------------------------------------------------------------------
interface sbox_lane_pipe_if #(
   parameter int unsigned LANES = 16,
   parameter int unsigned TAG_W = 4
);
   logic                 in_valid;
   logic                 in_ready;
   logic                 in_inv;
   logic [8*LANES-1:0]   in_data;
   logic [TAG_W-1:0]     in_tag;
   logic                 out_valid;
   logic                 out_ready;
   logic [8*LANES-1:0]   out_data;
   logic [TAG_W-1:0]     out_tag;

   modport slave (
      input  in_valid, in_inv, in_data, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_tag
   );

   modport master (
      output in_valid, in_inv, in_data, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_tag
   );
endinterface

// File: rtl/sbox_lane_pipe.sv
// ----------------------------------------------------------------------------
// sbox_lane_pipe
// Elastic, multi-lane AES SubBytes / InvSubBytes engine. PIPE-1 register
// stages carry (data, inv, tag, valid); a final stage registers the looked-up
// bytes. Each stage loads whenever it is empty or draining, so bubbles close
// and there is no global stall.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; discards everything in flight
//   bus    sbox_lane_pipe_if.slave (upstream + downstream valid/ready)
//   busy   any stage holds a valid transaction
// ----------------------------------------------------------------------------
module sbox_lane_pipe #(
   parameter int unsigned LANES = 16,
   parameter int unsigned PIPE  = 2,
   parameter int unsigned TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   sbox_lane_pipe_if.slave  bus,
   output logic             busy
);

   localparam int unsigned DW = 8 * LANES;

   // GF(2^8) multiply, AES polynomial x^8+x^4+x^3+x+1
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = '0;
      aa = a;
      for (int unsigned i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (maps 0 to 0)
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = a;
      acc = 8'h01;
      for (int unsigned i = 0; i < 7; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   // Forward S-box = affine(inv(x)); inverse S-box = inv(inv_affine(x)).
   // Both directions share one field inverter per lane.
   function automatic logic [7:0] sub_byte(input logic [7:0] a, input logic inv);
      logic [7:0] pre;
      logic [7:0] y;
      if (inv)
         pre = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
      else
         pre = a;
      y = gf_inv(pre);
      if (inv)
         return y;
      return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]}
               ^ {y[3:0], y[7:4]} ^ 8'h63;
   endfunction

   logic [PIPE-1:0]  r_vld;
   logic [PIPE-1:0]  w_rdy;        // stage s may load this cycle
   logic [DW-1:0]    r_out_data;
   logic [TAG_W-1:0] r_out_tag;

   // Source of the lookup stage
   logic             w_lk_vld;
   logic             w_lk_inv;
   logic [DW-1:0]    w_lk_data;
   logic [TAG_W-1:0] w_lk_tag;
   logic [DW-1:0]    w_sub;

   // Ready ripples from out_ready back to stage 0 through each stage's valid
   always_comb begin
      logic w_down;
      w_rdy  = '0;
      w_down = bus.out_ready;
      for (int unsigned k = 0; k < PIPE; k++) begin
         w_rdy[PIPE-1-k] = !r_vld[PIPE-1-k] || w_down;
         w_down          = w_rdy[PIPE-1-k];
      end
   end

   assign bus.in_ready  = rst_n && w_rdy[0];
   assign bus.out_valid = r_vld[PIPE-1];
   assign bus.out_data  = r_out_data;
   assign bus.out_tag   = r_out_tag;
   assign busy          = |r_vld;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld <= '0;
      end else begin
         if (w_rdy[0]) r_vld[0] <= bus.in_valid;
         for (int unsigned s = 1; s < PIPE; s++) begin
            if (w_rdy[s]) r_vld[s] <= r_vld[s-1];
         end
      end
   end

   generate
      if (PIPE > 1) begin : g_in_stages
         logic [DW-1:0]    r_data [PIPE-1];
         logic [TAG_W-1:0] r_tag  [PIPE-1];
         logic [PIPE-2:0]  r_inv;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_inv <= '0;
               for (int unsigned s = 0; s < PIPE - 1; s++) begin
                  r_data[s] <= '0;
                  r_tag[s]  <= '0;
               end
            end else begin
               if (w_rdy[0] && bus.in_valid) begin
                  r_data[0] <= bus.in_data;
                  r_tag[0]  <= bus.in_tag;
                  r_inv[0]  <= bus.in_inv;
               end
               for (int unsigned s = 1; s < PIPE - 1; s++) begin
                  if (w_rdy[s] && r_vld[s-1]) begin
                     r_data[s] <= r_data[s-1];
                     r_tag[s]  <= r_tag[s-1];
                     r_inv[s]  <= r_inv[s-1];
                  end
               end
            end
         end

         assign w_lk_vld  = r_vld[PIPE-2];
         assign w_lk_inv  = r_inv[PIPE-2];
         assign w_lk_data = r_data[PIPE-2];
         assign w_lk_tag  = r_tag[PIPE-2];
      end else begin : g_direct
         assign w_lk_vld  = bus.in_valid;
         assign w_lk_inv  = bus.in_inv;
         assign w_lk_data = bus.in_data;
         assign w_lk_tag  = bus.in_tag;
      end
   endgenerate

   always_comb begin
      w_sub = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
         w_sub[8*l +: 8] = sub_byte(w_lk_data[8*l +: 8], w_lk_inv);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_data <= '0;
         r_out_tag  <= '0;
      end else if (w_rdy[PIPE-1] && w_lk_vld) begin
         r_out_data <= w_sub;
         r_out_tag  <= w_lk_tag;
      end
   end

endmodule

// File: doc/sbox_lane_pipe.md
Name: sbox_lane_pipe

Overview:
- Multi-lane, pipelined AES byte-substitution engine for the AES-256 datapath.
- Applies the forward S-box (encrypt) or the inverse S-box (decrypt) to LANES bytes in parallel. Mode is selected per transaction.
- Elastic valid/ready pipeline with full backpressure, sitting between the round-state register and ShiftRows/MixColumns.
- Also serves the key-expansion SubWord path (LANES=4).

Parameters:
- LANES, 16, number of bytes substituted per transaction (1..16).
- PIPE, 2, pipeline depth in cycles from accept to out_valid (1..4).
- TAG_W, 4, width of the sideband tag carried alongside the data (round number etc.).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept the input this cycle.
- in_inv  in  1  0 = forward S-box, 1 = inverse S-box.
- in_data  in  8*LANES  input bytes; lane k = in_data[8k+7:8k].
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  output transaction valid.
- out_ready  in  1  downstream accepts the output.
- out_data  out  8*LANES  substituted bytes, same lane order as the input.
- out_tag  out  TAG_W  tag of the transaction.
- busy  out  1  any pipeline stage holds a valid transaction.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All stage valid bits clear.
  - out_valid=0, out_data=0, out_tag=0, busy=0.
  - in_ready=0 while rst_n is low, and 1 from the first cycle after release.
- Handshakes:
  - An input is accepted on a clk edge when in_valid&&in_ready.
  - An output is consumed on a clk edge when out_valid&&out_ready.
- Stage structure:
  - PIPE-1 input register stages (data, inv, tag, valid), followed by one combined lookup+output register stage.
  - The lookup is combinational from the last input register, or directly from the input ports when PIPE=1.
- Stage advance rule (per stage s):
  - Stage s loads from stage s-1 when stage s is empty or stage s is itself advancing this cycle.
  - The final stage advances when out_ready=1.
  - A bubble in any stage is closed; there is no global stall.
- in_ready = !stage0_valid || stage0_advancing. This is combinational from out_ready through the chain.
- Latency:
  - Exactly PIPE cycles from accept to out_valid when there is no backpressure.
  - Throughput is one transaction per cycle sustained.
- Backpressure:
  - While out_valid=1 and out_ready=0, out_data, out_tag and out_valid hold stable.
  - Upstream stages fill; once all are full, in_ready=0.
  - No transaction is dropped or duplicated.
- Per-lane function:
  - out byte k = SBOX(in byte k) when inv=0, and INV_SBOX(in byte k) when inv=1.
  - Tables are the FIPS-197 tables.
  - inv is latched with its transaction, so mixed modes in flight are legal.
- Ordering: strict FIFO order, with the tag travelling with its data.
- busy = OR of all stage valid bits.
- Reset mid-operation: all in-flight transactions are discarded. No output is produced for them after reset release.
- Simultaneous accept and consume on a full pipeline: both occur in the same cycle and occupancy is unchanged.
- Unused-lane rules do not apply: every lane is always processed.

Test Plan:
- Reset and latency:
  - Stimulus: PIPE=2, LANES=4. Release reset, then drive in_data=32'hff53_0100, inv=0, tag=3, with out_ready=1.
  - Required: out_valid asserts exactly 2 cycles after accept, with out_data=32'h16ed_7c63 and out_tag=3. in_ready=1 the cycle after reset release.
- Inverse mode:
  - Stimulus: in_data=32'h16ed_7c63, inv=1.
  - Required: out_data=32'hff53_0100.
  - Stimulus: in_data=32'h0000_0000, inv=1.
  - Required: out_data=32'h5252_5252.
- Exhaustive round trip:
  - Stimulus: stream all 256 byte values across lanes back-to-back in forward mode, then feed the results back with inv=1.
  - Required: the original bytes are recovered. Throughput is 1 per cycle with no gaps in out_valid.
- Backpressure:
  - Stimulus: push 6 transactions with tags 0..5 while out_ready=0.
  - Required: in_ready drops after PIPE accepts, and out_data is held stable.
  - Stimulus: then toggle out_ready 1/0 randomly.
  - Required: tags emerge 0..5 in order, with no loss or duplicates.
- Mixed modes in flight:
  - Stimulus: alternate inv=0/1 every cycle on byte 8'h53.
  - Required: outputs alternate 8'hed / 8'h50 (INV_SBOX(53)=50).
- Reset mid-flight:
  - Stimulus: assert rst_n low asynchronously while 2 transactions are in flight.
  - Required: out_valid=0 and busy=0 immediately. No stale output after release. A new transaction returns correct data after PIPE cycles.
